// File: rtl/act_unit.sv
// act_unit: two-stage pipelined per-lane activation (bypass, ReLU, leaky ReLU,
// clipped ReLU) with a saturating counter of lanes the activation changed.
//
// Handshake: a beat moves across a port on a rising edge where valid and ready
// are both high. The producer holds valid and the beat steady until accepted.
// A stage takes a new beat when it is empty or its current beat leaves in the
// same cycle. in_ready therefore depends combinationally on out_ready.
module act_unit #(
    parameter int DATA_W  = 8,
    parameter int LANES   = 4,
    parameter int LEAK_SH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [1:0]              mode,
    input  logic [DATA_W-1:0]       clip_max,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    clr_cnt,
    output logic [15:0]             mod_cnt
);

    localparam int W  = LANES * DATA_W;
    localparam int CW = $clog2(LANES + 1);

    // Stage 1: raw beat plus the controls that travel with it.
    logic              s1_valid;
    logic [W-1:0]      s1_data;
    logic [1:0]        s1_mode;
    logic [DATA_W-1:0] s1_clip;

    // Stage 2: computed result and how many of its lanes were changed.
    logic              s2_valid;
    logic [W-1:0]      s2_data;
    logic [CW-1:0]     s2_mod;

    logic              s2_adv;
    logic [W-1:0]      act_data;
    logic [CW-1:0]     act_mod;
    logic [16:0]       cnt_sum;

    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign cnt_sum   = {1'b0, mod_cnt} + 17'(s2_mod);

    // One lane of the activation. A negative clip bound forces 0 in clipped
    // mode, so the bound is never passed through when it is below zero.
    function automatic logic [DATA_W-1:0] lane_act(
        input logic [DATA_W-1:0] x,
        input logic [1:0]        m,
        input logic [DATA_W-1:0] clip
    );
        logic signed [DATA_W-1:0] xs;
        logic signed [DATA_W-1:0] cs;
        logic [DATA_W-1:0]        r;
        xs = $signed(x);
        cs = $signed(clip);
        r  = x;
        case (m)
            2'b01: if (xs < 0) r = '0;
            2'b10: if (xs < 0) r = xs >>> LEAK_SH;
            2'b11: begin
                if (xs < 0 || cs < 0) r = '0;
                else if (xs > cs)     r = clip;
            end
            default: r = x;
        endcase
        return r;
    endfunction

    // Activation of every lane of the stage-1 beat and count of changed lanes.
    always_comb begin
        act_data = '0;
        act_mod  = '0;
        for (int k = 0; k < LANES; k++) begin
            act_data[k*DATA_W +: DATA_W] = lane_act(s1_data[k*DATA_W +: DATA_W], s1_mode, s1_clip);
            if (act_data[k*DATA_W +: DATA_W] != s1_data[k*DATA_W +: DATA_W])
                act_mod = act_mod + CW'(1);
        end
    end

    // Stage 1 register: load whenever it can accept; empties if nothing arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= 2'b00;
            s1_clip  <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_mode <= mode;
                s1_clip <= clip_max;
            end
        end
    end

    // Stage 2 register: holds the result steady while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_mod   <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= act_data;
                s2_mod  <= act_mod;
            end
        end
    end

    // Saturating modified-lane counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mod_cnt <= 16'h0000;
        end else if (clr_cnt) begin
            mod_cnt <= 16'h0000;
        end else if (s2_valid && out_ready) begin
            mod_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

endmodule

// File: tb/tb_act_unit.sv
// tb_act_unit: randomized and directed stimulus for act_unit, checked against
// an arithmetic reference model through a scoreboard of expected beats.
module tb_act_unit;

    localparam int DW = 8;
    localparam int LN = 4;
    localparam int SH = 3;
    localparam int W  = DW * LN;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    mode;
    logic [DW-1:0] clip_max;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          clr_cnt;
    logic [15:0]   mod_cnt;

    act_unit #(.DATA_W(DW), .LANES(LN), .LEAK_SH(SH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mode(mode), .clip_max(clip_max),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .clr_cnt(clr_cnt), .mod_cnt(mod_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int           cnt_q[$];
    int           model_cnt;
    int           in_flight;
    int           delivered;
    int           n_checks;
    int           n_errors;
    logic         accepted;
    logic         ov_at_neg;
    logic [W-1:0] last_out;
    logic         stall_pending;
    logic [W-1:0] stall_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: apply the activation rules lane by lane with integers.
    task automatic model_beat(input logic [W-1:0] d, input logic [1:0] m, input logic [DW-1:0] c,
                              output logic [W-1:0] r, output int n);
        int x, y, cl, dv;
        logic signed [DW-1:0] lv, cv;
        r  = '0;
        n  = 0;
        cv = c;
        cl = int'(cv);
        dv = 1 << SH;
        for (int k = 0; k < LN; k++) begin
            lv = d[k*DW +: DW];
            x  = int'(lv);
            case (m)
                2'd0: y = x;
                2'd1: y = (x < 0) ? 0 : x;
                2'd2: y = (x < 0) ? (x - (dv - 1)) / dv : x;
                default: begin
                    if (x < 0 || cl < 0) y = 0;
                    else if (x > cl)     y = cl;
                    else                 y = x;
                end
            endcase
            if (y != x) n++;
            r[k*DW +: DW] = DW'(y);
        end
    endtask

    // One clock: observe handshakes at negedge, update model, check counter.
    task automatic tick();
        logic [W-1:0] e;
        int           n;
        @(negedge clk);
        accepted  = 1'b0;
        ov_at_neg = out_valid;
        check("in_ready", in_ready, !(in_flight == 2 && !out_ready));
        if (stall_pending) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_data", out_data, stall_data);
        end
        stall_pending = out_valid && !out_ready;
        stall_data    = out_data;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                n = cnt_q.pop_front();
                check("out_data", out_data, e);
                last_out  = out_data;
                model_cnt = (model_cnt + n > 65535) ? 65535 : model_cnt + n;
                delivered++;
                in_flight--;
            end
        end
        if (clr_cnt) model_cnt = 0;
        if (in_valid && in_ready) begin
            model_beat(in_data, mode, clip_max, e, n);
            exp_q.push_back(e);
            cnt_q.push_back(n);
            in_flight++;
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
        check("mod_cnt", mod_cnt, 64'(model_cnt));
    endtask

    // driver: present a beat and hold it until accepted (bounded wait)
    task automatic drive_beat(input logic [W-1:0] d, input logic [1:0] m, input logic [DW-1:0] c);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        clip_max = c;
        t = 0;
        do begin
            tick();
            t++;
        end while (!accepted && t < 50);
        check("accept_timeout", accepted, 1'b1);
    endtask

    task automatic drain();
        int t;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        t = 0;
        while (in_flight > 0 && t < 100) begin
            tick();
            t++;
        end
        check("drain", 64'(in_flight), 64'd0);
    endtask

    initial begin
        int           sent, cyc, d0;
        logic [7:0]   pat;
        n_checks = 0; n_errors = 0; model_cnt = 0; in_flight = 0; delivered = 0;
        stall_pending = 1'b0; stall_data = '0; last_out = '0; accepted = 1'b0; ov_at_neg = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = 2'b00; clip_max = '0;
        out_ready = 1'b1; clr_cnt = 1'b0;

        // reset state
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_mod_cnt", mod_cnt, 16'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1'b1);

        // ReLU with latency check
        drive_beat(32'h8007_00FB, 2'b01, 8'd0);
        in_valid = 1'b0;
        tick();
        check("lat_edge1", ov_at_neg, 1'b0);
        tick();
        check("lat_edge2", ov_at_neg, 1'b1);
        check("relu_data", last_out, 32'h0007_0000);
        check("relu_cnt", mod_cnt, 16'd2);

        // leaky ReLU: -16->-2, -1->-1, -7->-1, 100->100 (two lanes change)
        drive_beat(32'h64F9_FFF0, 2'b10, 8'd0);
        drain();
        check("leaky_data", last_out, 32'h64FF_FFFE);
        check("leaky_cnt", mod_cnt, 16'd4);

        // clipped ReLU, then a negative bound on back-to-back beats
        drive_beat(32'h7F07_06FD, 2'b11, 8'd6);
        drive_beat(32'h0505_0505, 2'b11, 8'hFF);
        in_valid = 1'b0;
        tick();
        check("clip_data", last_out, 32'h0606_0600);
        drain();
        check("clipneg_data", last_out, 32'h0000_0000);
        check("clip_cnt", mod_cnt, 16'd11);

        // 8-beat stream with out_ready pattern 1,0,0,1,0,1,1,1
        pat = 8'b1110_1001;
        sent = 0; cyc = 0; d0 = delivered;
        while ((sent < 8 || in_flight > 0) && cyc < 200) begin
            if (!in_valid && sent < 8) begin
                in_valid = 1'b1;
                in_data  = W'($urandom);
                mode     = 2'($urandom_range(0, 3));
                clip_max = DW'($urandom);
            end
            out_ready = (cyc < 8) ? pat[cyc] : 1'b1;
            tick();
            if (accepted) begin
                sent++;
                in_valid = 1'b0;
            end
            cyc++;
        end
        check("stream_delivered", 64'(delivered - d0), 64'd8);

        // randomized traffic with random back-pressure and occasional clears
        for (int i = 0; i < 400; i++) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = W'($urandom);
                mode     = 2'($urandom_range(0, 3));
                clip_max = DW'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            clr_cnt   = ($urandom_range(0, 31) == 0);
            tick();
            if (accepted) in_valid = 1'b0;
        end
        clr_cnt = 1'b0;
        drain();

        // reset with two beats in flight
        drive_beat(32'hFFFF_FFFF, 2'b01, 8'd0);
        out_ready = 1'b0;
        drive_beat(32'h8080_8080, 2'b01, 8'd0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, '0);
        check("midrst_mod_cnt", mod_cnt, 16'h0);
        exp_q.delete(); cnt_q.delete();
        in_flight = 0; model_cnt = 0; stall_pending = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("postrst_idle", ov_at_neg, 1'b0);
        end

        // saturation: preload 0xFFFE, then push past it
        for (int i = 0; i < 16383; i++) begin
            drive_beat(32'hFFFF_FFFF, 2'b01, 8'd0);
        end
        drive_beat(32'h0101_FFFF, 2'b01, 8'd0);
        drain();
        check("sat_fffe", mod_cnt, 16'hFFFE);
        drive_beat(32'hFFFF_FFFF, 2'b01, 8'd0);
        drain();
        check("sat_ffff", mod_cnt, 16'hFFFF);
        drive_beat(32'hFFFF_FFFF, 2'b01, 8'd0);
        drain();
        check("sat_hold", mod_cnt, 16'hFFFF);

        // clear during a counting output transfer
        drive_beat(32'hFFFF_FFFF, 2'b01, 8'd0);
        in_valid = 1'b0;
        tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_fire", ov_at_neg, 1'b1);
        check("clr_cnt", mod_cnt, 16'h0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
